// File: rtl/key_state_tracker_pkg.sv
// key_state_tracker_pkg: shared scancodes, key bit indices and receiver state encoding
package key_state_tracker_pkg;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [1:0] KEY_LEFT    = 2'd0;
    localparam logic [1:0] KEY_RIGHT   = 2'd1;
    localparam logic [1:0] KEY_JUMP    = 2'd2;
    localparam logic [1:0] KEY_RESTART = 2'd3;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
endpackage

// File: rtl/key_state_tracker_ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line synchronizer, clock glitch filter, frame receiver FSM and watchdog
//   clk, rst            system clock, async active-high reset
//   ps2_clk_i/ps2_data_i raw PS/2 lines
//   byte_o              last received byte (valid while byte_valid_o is high)
//   byte_valid_o        one-cycle pulse per accepted frame
//   frame_err_o         one-cycle pulse on bad parity/stop bit or watchdog expiry
module ps2_frame_rx
    import key_state_tracker_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    rx_state_e     state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_ok_q;
    logic [WW-1:0] wd_q;
    logic          bit_edge, expire, data_bit;
    // flt_cnt counts consecutive samples disagreeing with the filtered level
    always_comb begin
        data_bit  = data_sync_q[1];
        flt_cnt_d = (clk_sync_q[1] == filt_q || flt_cnt_q == FLT_LAST) ? '0 : flt_cnt_q + FW'(1);
        filt_d    = (clk_sync_q[1] != filt_q && flt_cnt_q == FLT_LAST) ? clk_sync_q[1] : filt_q;
        bit_edge  = filt_q & ~filt_d;
        expire    = state_q != RX_IDLE && wd_q == WD_MAX;
    end
    // idle-level reset keeps the filter from seeing a falling edge when rst drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            flt_cnt_q   <= flt_cnt_d;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_ok_q     <= 1'b0;
            wd_q         <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            wd_q         <= (state_q == RX_IDLE || bit_edge) ? '0 : (wd_q == WD_MAX ? wd_q : wd_q + WW'(1));
            // expiry takes priority: a coincident bit edge is dropped
            if (expire) begin
                state_q     <= RX_IDLE;
                frame_err_o <= 1'b1;
            end else if (bit_edge) begin
                case (state_q)
                    RX_IDLE: if (!data_bit) begin
                        state_q   <= RX_DATA;
                        bit_cnt_q <= '0;
                    end
                    RX_DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_ok_q <= ^{data_bit, shift_q};
                        state_q  <= RX_STOP;
                    end
                    default: begin
                        if (data_bit && par_ok_q) byte_valid_o <= 1'b1;
                        else frame_err_o <= 1'b1;
                        state_q <= RX_IDLE;
                    end
                endcase
            end
        end
    end
    assign byte_o = shift_q;
endmodule

// File: rtl/key_state_tracker.sv
// key_state_tracker: decodes PS/2 set-2 scancodes into a held-key bitmap for four game keys
//   clk, rst           system clock, async active-high reset
//   ps2_clk, ps2_data  raw PS/2 lines
//   keys               held keys: [0] left, [1] right, [2] jump (lshift), [3] restart (R)
//   key_event          one-cycle pulse when any keys bit changes
//   frame_err          one-cycle pulse on a rejected frame or watchdog expiry
module key_state_tracker
    import key_state_tracker_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] keys,
    output logic       key_event,
    output logic       frame_err
);
    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    logic       ext_q, brk_q, key_event_q;
    logic [3:0] keys_q;
    logic       hit;
    logic [1:0] idx;
    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );
    always_comb begin
        hit = ext_q ? (rx_byte == SC_LEFT || rx_byte == SC_RIGHT) : (rx_byte == SC_LSHIFT || rx_byte == SC_R);
        idx = ext_q ? (rx_byte == SC_LEFT ? KEY_LEFT : KEY_RIGHT) : (rx_byte == SC_LSHIFT ? KEY_JUMP : KEY_RESTART);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keys_q      <= '0;
            key_event_q <= 1'b0;
        end else begin
            key_event_q <= 1'b0;
            if (rx_err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) ext_q <= 1'b1;
                else if (rx_byte == SC_BRK) brk_q <= 1'b1;
                else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    // bit changes exactly when its old value equals brk (new value is ~brk)
                    if (hit) begin
                        keys_q[idx] <= ~brk_q;
                        key_event_q <= keys_q[idx] == brk_q;
                    end
                end
            end
        end
    end
    assign keys      = keys_q;
    assign key_event = key_event_q;
    assign frame_err = rx_err;
endmodule

// File: tb/tb_key_state_tracker.sv
// tb_key_state_tracker: directed + randomized PS/2 frames checked against a frame-level key model
module tb_key_state_tracker;
    localparam int FL = 4;
    localparam int TO = 200;
    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [3:0] keys;
    logic       key_event, frame_err;
    key_state_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keys(keys), .key_event(key_event), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0, ev_cnt = 0, err_cnt = 0, cyc = 0, last_err_cyc = 0, half = 16;
    logic chk_en = 1'b0, err_prev = 1'b0;
    logic [3:0] m_keys = 4'b0;
    logic m_ext = 1'b0, m_brk = 1'b0;
    int m_ev = 0, m_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // the single compare process: every wait goes through here
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (key_event) ev_cnt++;
        if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
            chk("frame_err_width", int'(err_prev), 0);
        end
        err_prev = frame_err;
        if (chk_en) chk("keys", int'(keys), int'(m_keys));
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [10:0] fbits(input logic [7:0] b, input logic pf, input logic sb);
        return {~sb, (~^b) ^ pf, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_n(half);
            ps2_clk = 1'b0;
            wait_n(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // keyboard semantics at byte granularity
    task automatic model(input logic [7:0] b, input logic ok);
        int k;
        k = -1;
        if (!ok) begin
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_ext && b == 8'h6B) k = 0;
            if (m_ext && b == 8'h74) k = 1;
            if (!m_ext && b == 8'h12) k = 2;
            if (!m_ext && b == 8'h2D) k = 3;
            if (k >= 0 && m_keys[k] != !m_brk) begin
                m_keys[k] = !m_brk;
                m_ev++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [7:0] b, input logic pf = 1'b0, input logic sb = 1'b0);
        int ev0, er0, mev0, mer0;
        ev0 = ev_cnt; er0 = err_cnt; mev0 = m_ev; mer0 = m_err;
        chk_en = 1'b0;
        send_bits(fbits(b, pf, sb), 11);
        wait_n(half);
        model(b, !(pf || sb));
        chk_en = 1'b1;
        wait_n(4);
        chk("key_event_count", ev_cnt - ev0, m_ev - mev0);
        chk("frame_err_count", err_cnt - er0, m_err - mer0);
    endtask

    initial begin
        int e, er, t_fall, n;
        logic [7:0] tbl [8];
        tbl = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h12, 8'h2D, 8'hAA, 8'hFA};
        wait_n(3);
        chk("reset_keys", int'(keys), 0);
        chk("reset_key_event", int'(key_event), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        wait_n(5);
        e = ev_cnt;
        do_frame(8'hE0); do_frame(8'h6B);
        chk("left_make_keys", int'(keys), 4'b0001);
        chk("left_make_events", ev_cnt - e, 1);
        e = ev_cnt;
        do_frame(8'hE0); do_frame(8'hF0); do_frame(8'h6B);
        chk("left_break_keys", int'(keys), 4'b0000);
        chk("left_break_events", ev_cnt - e, 1);
        e = ev_cnt;
        do_frame(8'h12); do_frame(8'h12); do_frame(8'h12);
        chk("jump_repeat_keys", int'(keys), 4'b0100);
        chk("jump_repeat_events", ev_cnt - e, 1);
        do_frame(8'hF0); do_frame(8'h12);
        chk("jump_break_keys", int'(keys), 4'b0000);
        er = err_cnt;
        do_frame(8'h2D, 1'b1);
        chk("bad_parity_err", err_cnt - er, 1);
        chk("bad_parity_keys", int'(keys), 4'b0000);
        do_frame(8'h2D);
        chk("restart_keys", int'(keys), 4'b1000);
        er = err_cnt;
        send_bits(fbits(8'h5A, 1'b0, 1'b0), 5);
        t_fall = cyc - half;
        n = 0;
        while (err_cnt == er && n < 300) begin tick(); n++; end
        chk("watchdog_timing", int'((last_err_cyc - t_fall) >= TO && (last_err_cyc - t_fall) <= TO + FL + 8), 1);
        wait_n(250 - n > 0 ? 250 - n : 1);
        chk("watchdog_err", err_cnt - er, 1);
        model(8'h00, 1'b0);
        do_frame(8'hF0); do_frame(8'h2D);
        chk("after_watchdog_keys", int'(keys), 4'b0000);
        e = ev_cnt; er = err_cnt;
        repeat (5) begin
            ps2_clk = 1'b0; wait_n(2);
            ps2_clk = 1'b1; wait_n(10);
        end
        chk("glitch_events", ev_cnt - e, 0);
        chk("glitch_errs", err_cnt - er, 0);
        do_frame(8'hE0); do_frame(8'h12);
        chk("ext_shift_keys", int'(keys), 4'b0000);
        chk("ext_shift_events", ev_cnt - e, 0);
        do_frame(8'hE0); do_frame(8'h6B); do_frame(8'hE0); do_frame(8'h74);
        chk("two_arrows_keys", int'(keys), 4'b0011);
        do_frame(8'hE0); do_frame(8'hF0);
        rst = 1'b1;
        #1;
        chk("rst_async_keys", int'(keys), 0);
        m_keys = 4'b0; m_ext = 1'b0; m_brk = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(4);
        do_frame(8'h74);
        chk("after_rst_74_keys", int'(keys), 4'b0000);
        er = err_cnt;
        send_bits(fbits(8'h12, 1'b0, 1'b0), 6);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(TO + 20);
        chk("midframe_rst_no_err", err_cnt - er, 0);
        do_frame(8'h12);
        chk("midframe_rst_resume", int'(keys), 4'b0100);
        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            half = $urandom_range(12, 20);
            b = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 7)] : 8'($urandom);
            do_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
